// File: rtl/nes_bus_arb.sv
// nes_bus_arb: arbitrates the NES CPU-side bus between the 6502 core and the
// sprite-DMA engine. DMA is only granted once the CPU is stalled on a read,
// and the grant is aligned to an odd CPU cycle using a free-running parity bit.
// Optional watchdog: define NES_BUS_ARB_TIMEOUT_EN to bound GRANT to 1024
// cycles and raise the sticky o_timeout flag. Without it GRANT is unbounded.
module nes_bus_arb (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_wn,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_rdy,
  input  logic        i_spr_req,
  output logic        o_spr_gnt,
  input  logic [15:0] i_spr_addr,
  input  logic        i_spr_wn,
  input  logic [7:0]  i_spr_wdata,
  output logic [7:0]  o_spr_rdata,
  output logic [15:0] o_bus_addr,
  output logic        o_bus_wn,
  output logic [7:0]  o_bus_wdata,
  input  logic [7:0]  i_bus_rdata,
  output logic        o_timeout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HALT    = 3'd1,
    ALIGN   = 3'd2,
    GRANT   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   r_par;
  logic   rdy_nxt;
  logic   gnt_nxt;
  logic   req_ok;     // DMA request as seen by the FSM (masked after a forced release)
  logic   force_rel;  // watchdog expiry in GRANT

`ifdef NES_BUS_ARB_TIMEOUT_EN
  logic [10:0] wd_cnt;
  logic        wd_blk;   // set on forced release, cleared once i_spr_req is seen low
  logic        wd_flag;

  // The 1024th GRANT cycle ends the transfer (count runs 0..1023 while granted).
  assign force_rel = (state == GRANT) && (wd_cnt == 11'd1023);
  assign req_ok    = i_spr_req && !wd_blk;
  assign o_timeout = wd_flag;

  // Watchdog counter, request mask and sticky timeout flag.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wd_cnt  <= 11'd0;
      wd_blk  <= 1'b0;
      wd_flag <= 1'b0;
    end else begin
      if (state != GRANT && state_nxt == GRANT)
        wd_cnt <= 11'd0;
      else if (state == GRANT)
        wd_cnt <= wd_cnt + 11'd1;

      if (force_rel)
        wd_blk <= 1'b1;
      else if (!i_spr_req)
        wd_blk <= 1'b0;

      if (force_rel)
        wd_flag <= 1'b1;
    end
  end
`else
  assign force_rel = 1'b0;
  assign req_ok    = i_spr_req;
  assign o_timeout = 1'b0;
`endif

  // State register, cycle parity and registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      r_par     <= 1'b0;
      o_cpu_rdy <= 1'b1;
      o_spr_gnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      r_par     <= ~r_par;
      o_cpu_rdy <= rdy_nxt;
      o_spr_gnt <= gnt_nxt;
    end
  end

  // Next-state logic: a dropped request in HALT/ALIGN aborts straight to IDLE;
  // writes are let through in HALT; GRANT is entered only on a sampled odd cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_ok)
          state_nxt = HALT;
      end
      HALT: begin
        if (!req_ok)
          state_nxt = IDLE;
        else if (i_cpu_wn)
          state_nxt = ALIGN;
      end
      ALIGN: begin
        if (!req_ok)
          state_nxt = IDLE;
        else if (r_par)
          state_nxt = GRANT;
      end
      GRANT: begin
        if (!req_ok || force_rel)
          state_nxt = RELEASE;
      end
      RELEASE: begin
        // Requests are not honoured here so the CPU always gets a ready cycle.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state so the handshake outputs come straight from flops.
  always_comb begin
    rdy_nxt = (state_nxt == IDLE);
    gnt_nxt = (state_nxt == GRANT);
  end

  // Shared-bus mux: DMA owns the bus in GRANT; once a CPU read has been
  // sampled (ALIGN, RELEASE) the bus direction is pinned to read.
  always_comb begin
    o_bus_addr  = i_cpu_addr;
    o_bus_wn    = i_cpu_wn;
    o_bus_wdata = i_cpu_wdata;
    case (state)
      GRANT: begin
        o_bus_addr  = i_spr_addr;
        o_bus_wn    = i_spr_wn;
        o_bus_wdata = i_spr_wdata;
      end
      ALIGN, RELEASE: begin
        o_bus_wn = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_cpu_rdata = i_bus_rdata;
  assign o_spr_rdata = i_bus_rdata;

endmodule

// File: tb/tb_nes_bus_arb.sv
// tb_nes_bus_arb: directed self-checking bench for nes_bus_arb.
// Inputs change just after the falling edge; outputs are checked mid-cycle.
module tb_nes_bus_arb;

  logic        clk;
  logic        rstn;
  logic [15:0] cpu_addr;
  logic        cpu_wn;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic        spr_req;
  logic        spr_gnt;
  logic [15:0] spr_addr;
  logic        spr_wn;
  logic [7:0]  spr_wdata;
  logic [7:0]  spr_rdata;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        timeout;

  int n_chk;
  int n_bad;
  int ncyc;   // rising edges since reset release; its LSB is the parity sampled next

  nes_bus_arb dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wn    (cpu_wn),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_rdy   (cpu_rdy),
    .i_spr_req   (spr_req),
    .o_spr_gnt   (spr_gnt),
    .i_spr_addr  (spr_addr),
    .i_spr_wn    (spr_wn),
    .i_spr_wdata (spr_wdata),
    .o_spr_rdata (spr_rdata),
    .o_bus_addr  (bus_addr),
    .o_bus_wn    (bus_wn),
    .o_bus_wdata (bus_wdata),
    .i_bus_rdata (bus_rdata),
    .o_timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_par(input int p);
    while ((ncyc % 2) != p) cyc(1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int ngnt;
    int k;
    n_chk = 0;
    n_bad = 0;
    rstn = 1'b0;
    cpu_addr = 16'h0000; cpu_wn = 1'b1; cpu_wdata = 8'h00;
    spr_req = 1'b0; spr_addr = 16'h0000; spr_wn = 1'b1; spr_wdata = 8'h00;
    bus_rdata = 8'h00;

    // Reset state
    cyc(2);
    chk("rst_rdy", cpu_rdy, 1);
    chk("rst_gnt", spr_gnt, 0);
    chk("rst_timeout", timeout, 0);
    rstn = 1'b1;
    cyc(2);

    // Idle pass-through, read then write
    cpu_addr = 16'h2002; cpu_wn = 1'b1; bus_rdata = 8'h80; #1;
    chk("idle_addr", bus_addr, 16'h2002);
    chk("idle_cpu_rdata", cpu_rdata, 8'h80);
    chk("idle_spr_rdata", spr_rdata, 8'h80);
    chk("idle_rdy", cpu_rdy, 1);
    chk("idle_gnt", spr_gnt, 0);
    chk("idle_wn", bus_wn, 1);
    cpu_addr = 16'h0300; cpu_wn = 1'b0; cpu_wdata = 8'h5A; #1;
    chk("idle_w_addr", bus_addr, 16'h0300);
    chk("idle_w_wn", bus_wn, 0);
    chk("idle_w_wdata", bus_wdata, 8'h5A);

    // Typical DMA on a CPU read, request raised with parity 0 -> two ALIGN cycles
    cpu_wn = 1'b1; cpu_addr = 16'h8123;
    wait_par(0);
    spr_req = 1'b1; spr_addr = 16'h0200; spr_wn = 1'b1; spr_wdata = 8'hEE;
    cyc(1); // HALT
    chk("a_halt_rdy", cpu_rdy, 0);
    chk("a_halt_gnt", spr_gnt, 0);
    chk("a_halt_addr", bus_addr, 16'h8123);
    cyc(1); // ALIGN
    chk("a_align_gnt", spr_gnt, 0);
    cpu_wn = 1'b0; #1;
    chk("a_align_wn_forced", bus_wn, 1);
    cyc(1); // ALIGN again (even cycle sampled)
    chk("a_align2_gnt", spr_gnt, 0);
    chk("a_align2_rdy", cpu_rdy, 0);
    cyc(1); // GRANT
    chk("a_gnt", spr_gnt, 1);
    chk("a_gnt_rdy", cpu_rdy, 0);
    chk("a_gnt_addr", bus_addr, 16'h0200);
    spr_wn = 1'b0; spr_wdata = 8'h3C; #1;
    chk("a_gnt_wn", bus_wn, 0);
    chk("a_gnt_wdata", bus_wdata, 8'h3C);
    spr_wn = 1'b1;
    for (int i = 0; i < 512; i++) begin
      spr_addr = 16'h0200 + 16'(i % 256); #1;
      chk("a_hold_gnt", spr_gnt, 1);
      chk("a_hold_addr", bus_addr, 16'h0200 + 16'(i % 256));
      cyc(1);
    end
    chk("a_hold_timeout", timeout, 0);

    // Release, with a new request arriving during RELEASE
    spr_req = 1'b0;
    cyc(1); // RELEASE
    chk("r_gnt", spr_gnt, 0);
    chk("r_rdy", cpu_rdy, 0);
    chk("r_wn_forced", bus_wn, 1);
    chk("r_addr", bus_addr, 16'h8123);
    spr_req = 1'b1;
    cyc(1); // IDLE despite the request
    chk("r_idle_rdy", cpu_rdy, 1);
    chk("r_idle_gnt", spr_gnt, 0);
    chk("r_idle_wn", bus_wn, 0);
    cyc(1); // request honoured from IDLE -> HALT
    chk("r_rehalt_rdy", cpu_rdy, 0);
    spr_req = 1'b0;
    cyc(1); // abort from HALT
    chk("h_abort_rdy", cpu_rdy, 1);
    chk("h_abort_gnt", spr_gnt, 0);

    // Write deferral: HALT held while the CPU writes, then ALIGN (1 cycle) and GRANT
    wait_par(0);
    cpu_addr = 16'h4014; cpu_wn = 1'b0; cpu_wdata = 8'hC3; spr_req = 1'b1;
    cyc(1); // HALT
    chk("b_h1_rdy", cpu_rdy, 0);
    chk("b_h1_wn", bus_wn, 0);
    chk("b_h1_wdata", bus_wdata, 8'hC3);
    chk("b_h1_addr", bus_addr, 16'h4014);
    cyc(1); // still HALT
    chk("b_h2_rdy", cpu_rdy, 0);
    chk("b_h2_gnt", spr_gnt, 0);
    chk("b_h2_wn", bus_wn, 0);
    cpu_wn = 1'b1; #1;
    chk("b_h2_wn_pass", bus_wn, 1);
    cyc(1); // ALIGN
    chk("b_align_gnt", spr_gnt, 0);
    chk("b_align_rdy", cpu_rdy, 0);
    cyc(1); // GRANT
    chk("b_gnt", spr_gnt, 1);
    spr_addr = 16'h0210; #1;
    chk("b_gnt_addr", bus_addr, 16'h0210);

    // Reset asserted mid-GRANT hands the bus back immediately
    rstn = 1'b0; #1;
    chk("d_gnt", spr_gnt, 0);
    chk("d_rdy", cpu_rdy, 1);
    chk("d_addr", bus_addr, 16'h4014);
    chk("d_wn", bus_wn, 1);
    spr_req = 1'b0;
    cyc(1);
    rstn = 1'b1;
    cyc(2);
    chk("d_idle_rdy", cpu_rdy, 1);

    // Abort in ALIGN on a cycle that would otherwise have granted
    wait_par(1);
    cpu_wn = 1'b1; spr_req = 1'b1;
    cyc(1); // HALT
    cyc(1); // ALIGN
    chk("c_align_rdy", cpu_rdy, 0);
    chk("c_align_gnt", spr_gnt, 0);
    spr_req = 1'b0;
    cyc(1);
    chk("c_abort_rdy", cpu_rdy, 1);
    chk("c_abort_gnt", spr_gnt, 0);
    cyc(1);
    chk("c_abort2_gnt", spr_gnt, 0);

`ifdef NES_BUS_ARB_TIMEOUT_EN
    // Watchdog: 1024 grant cycles, sticky flag, no re-grant until request seen low
    wait_par(0);
    spr_req = 1'b1;
    cyc(4);
    chk("t_gnt", spr_gnt, 1);
    ngnt = 0;
    for (int i = 0; i < 2000; i++) begin
      if (spr_gnt) ngnt++;
      cyc(1);
    end
    chk("t_gnt_cycles", ngnt, 1024);
    chk("t_timeout", timeout, 1);
    chk("t_blocked_rdy", cpu_rdy, 1);
    chk("t_blocked_gnt", spr_gnt, 0);
    spr_req = 1'b0;
    cyc(1);
    spr_req = 1'b1;
    k = 0;
    while (!spr_gnt && k < 8) begin
      cyc(1);
      k++;
    end
    chk("t_regrant", spr_gnt, 1);
    chk("t_sticky", timeout, 1);
    spr_req = 1'b0;
    cyc(2);
`else
    // No watchdog: GRANT holds as long as the request does
    wait_par(0);
    spr_req = 1'b1;
    cyc(4);
    chk("u_gnt", spr_gnt, 1);
    ngnt = 0;
    for (int i = 0; i < 1100; i++) begin
      if (spr_gnt) ngnt++;
      cyc(1);
    end
    chk("u_gnt_cycles", ngnt, 1100);
    chk("u_timeout", timeout, 0);
    spr_req = 1'b0;
    cyc(2);
    chk("u_end_rdy", cpu_rdy, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
